// File: rtl/serial_frame_transmitter_pkg.sv
// Shared shifting definitions: FSM encodings used by the serial link blocks.
// Imported by the transmitter and its shift register.
package serial_frame_transmitter_pkg;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = STATE_IDLE,
    SHIFT = STATE_SHIFT
  } state_e;

endpackage

// File: rtl/parallel_load_shift_register.sv
// Parallel-load shift register with zero fill; load wins over enable.
// MSB_FIRST selects left (toward bit SIZE-1) or right shifting.
module parallel_load_shift_register
  import serial_frame_transmitter_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [SIZE-1:0] load_data,
  input  logic            enable,
  output logic [SIZE-1:0] q
);

  logic [SIZE-1:0] q_d;
  logic [SIZE-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_data;
    end else if (enable) begin
      if (MSB_FIRST) begin
        q_d = {q_q[SIZE-2:0], 1'b0};
      end else begin
        q_d = {1'b0, q_q[SIZE-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_frame_transmitter.sv
// Parallel-in serial-out frame transmitter with a one-word hold buffer.
// Frames run back to back so a same-enable receiver needs no framing gap.
module serial_frame_transmitter
  import serial_frame_transmitter_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] data_in,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic            enable,
  output logic            out,
  output logic            frame_start,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            fs_q, fs_d;
  logic            done_q, done_d;

  logic            accept;
  logic            eof;
  logic            sh_load;
  logic            sh_en;
  logic [SIZE-1:0] sh_data;
  logic [SIZE-1:0] sh_q;
  logic            sh_unused;

  assign load_ready = !hold_full_q;
  assign accept     = load_valid && !hold_full_q;
  assign eof        = (state_q == SHIFT) && enable && (cnt_q == LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    fs_d        = fs_q;
    done_d      = 1'b0;
    sh_load     = 1'b0;
    sh_en       = 1'b0;
    sh_data     = data_in;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sh_load = 1'b1;
          cnt_d   = '0;
          fs_d    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (accept && !eof) begin
          hold_d      = data_in;
          hold_full_d = 1'b1;
        end
        if (enable) begin
          sh_en = 1'b1;
          fs_d  = 1'b0;
          if (cnt_q == LAST) begin
            done_d = 1'b1;
            cnt_d  = '0;
            // Reload straight away so the next frame follows with no gap.
            if (hold_full_q) begin
              sh_load     = 1'b1;
              sh_data     = hold_q;
              hold_full_d = 1'b0;
              fs_d        = 1'b1;
            end else if (accept) begin
              sh_load = 1'b1;
              fs_d    = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      fs_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      fs_q        <= fs_d;
      done_q      <= done_d;
    end
  end

  parallel_load_shift_register #(
    .SIZE      (SIZE),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load      (sh_load),
    .load_data (sh_data),
    .enable    (sh_en),
    .q         (sh_q)
  );

  // The last shift of a frame fills with 0, so out idles low on its own.
  assign out         = MSB_FIRST ? sh_q[SIZE-1] : sh_q[0];
  assign sh_unused   = ^sh_q;
  assign frame_start = fs_q;
  assign busy        = (state_q == SHIFT);
  assign done        = done_q;

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Bench for serial_frame_transmitter: MSB- and LSB-first instances checked
// every cycle against a frame-queue reference model.
module tb_serial_frame_transmitter;

  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            load_valid = 1'b0;
  logic            enable = 1'b0;
  logic [SIZE-1:0] data_in = '0;

  logic out_m, fs_m, busy_m, done_m, lr_m;
  logic out_l, fs_l, busy_l, done_l, lr_l;

  int checks = 0;
  int fails = 0;

  serial_frame_transmitter #(.SIZE(SIZE), .MSB_FIRST(1'b1)) u_msb (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .load_valid  (load_valid),
    .load_ready  (lr_m),
    .enable      (enable),
    .out         (out_m),
    .frame_start (fs_m),
    .busy        (busy_m),
    .done        (done_m)
  );

  serial_frame_transmitter #(.SIZE(SIZE), .MSB_FIRST(1'b0)) u_lsb (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .load_valid  (load_valid),
    .load_ready  (lr_l),
    .enable      (enable),
    .out         (out_l),
    .frame_start (fs_l),
    .busy        (busy_l),
    .done        (done_l)
  );

  always #5 clk = ~clk;

  // Model: fq[0] is the frame on the wire, fq[1] the buffered one.
  logic [SIZE-1:0] fq[$];
  int              idx = 0;
  bit              done_exp = 1'b0;
  bit              init = 1'b0;
  bit              acc;

  always @(posedge clk) begin
    if (reset) begin
      fq.delete();
      idx      = 0;
      done_exp = 1'b0;
      init     = 1'b1;
    end else begin
      acc      = load_valid && (fq.size() < 2);
      done_exp = 1'b0;
      if (fq.size() > 0 && enable) begin
        if (idx == SIZE - 1) begin
          void'(fq.pop_front());
          idx      = 0;
          done_exp = 1'b1;
        end else begin
          idx++;
        end
      end
      if (acc) fq.push_back(data_in);
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  logic [SIZE-1:0] cur;
  logic em, el, eb, efs, elr;

  always @(negedge clk) begin
    if (init) begin
      eb  = fq.size() > 0;
      cur = eb ? fq[0] : '0;
      em  = eb ? cur[SIZE-1-idx] : 1'b0;
      el  = eb ? cur[idx] : 1'b0;
      efs = eb && (idx == 0);
      elr = fq.size() < 2;
      chk("out_msb", out_m, em);
      chk("out_lsb", out_l, el);
      chk("frame_start_msb", fs_m, efs);
      chk("frame_start_lsb", fs_l, efs);
      chk("busy_msb", busy_m, eb);
      chk("busy_lsb", busy_l, eb);
      chk("done_msb", done_m, done_exp);
      chk("done_lsb", done_l, done_exp);
      chk("load_ready_msb", lr_m, elr);
      chk("load_ready_lsb", lr_l, elr);
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [SIZE-1:0] w);
    int n;
    n = 0;
    data_in    = w;
    load_valid = 1'b1;
    while (fq.size() >= 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      fails++;
      $display("FAIL send_timeout actual=%0d required<200", n);
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;

    send(8'hA5);
    repeat (10) @(negedge clk);

    send(8'h01);
    repeat (10) @(negedge clk);

    send(8'hFF);
    send(8'h00);
    repeat (20) @(negedge clk);

    send(8'hC3);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    repeat (12) @(negedge clk);

    send(8'h3C);
    repeat (7) @(negedge clk);
    load_valid = 1'b1;
    data_in    = 8'h81;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (20) @(negedge clk);

    send(8'h96);
    send(8'h5A);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom_range(0, 3) != 0);
      load_valid = ($urandom_range(0, 1) != 0);
      data_in    = SIZE'($urandom);
      reset      = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    reset      = 1'b0;
    load_valid = 1'b0;
    enable     = 1'b1;
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_frame_transmitter.md
# serial_frame_transmitter

Parallel-in, serial-out transmitter forming the sending end of the serial shift links in the shifting library. It accepts SIZE-bit words over a valid/ready handshake, buffers one word ahead, and shifts each word out one bit per enabled clock. Frames follow one another with no idle gap, so a serial-in left shift register clocked with the same enable reassembles each word after SIZE enabled cycles.

## Interface
- SIZE, 8, word width in bits; legal range is 2 or more.
- MSB_FIRST, 1, 1 = bit SIZE-1 is sent first (matches left-shift receivers); 0 = bit 0 is sent first.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge.
- data_in  input  SIZE  word to transmit; sampled on an accepted load.
- load_valid  input  1  data_in is valid.
- load_ready  output  1  equals !hold_full; a load is accepted when load_valid && load_ready at a rising edge.
- enable  input  1  shift strobe; the serial stream advances only on enabled cycles.
- out  output  1  registered serial data bit.
- frame_start  output  1  registered; high while out carries the first bit of a frame.
- busy  output  1  high in the SHIFT state.
- done  output  1  registered one-cycle pulse after the last bit of a frame has been consumed.

## Operation
- State: FSM with IDLE and SHIFT states, a SIZE-bit shifter, a bit_count of width $clog2(SIZE), and a one-entry hold register with a hold_full flag.
- Reset values: state=IDLE, shifter=0, hold=0, hold_full=0, bit_count=0, out=0, frame_start=0, busy=0, done=0. load_ready reads 1 on the first cycle after reset.
- Accepted load in IDLE: the word goes directly into the shifter, bit_count=0, state becomes SHIFT, and frame_start=1. Enable is not required for this load.
- Accepted load in SHIFT: the word goes into hold and hold_full=1.
- Enabled cycle in SHIFT with bit_count < SIZE-1: the shifter moves toward the output end, bit_count increments, and frame_start clears.
- Enabled cycle in SHIFT with bit_count == SIZE-1 (end of frame): done pulses on the next cycle. What happens next depends on the buffer:
  - If hold_full, hold moves into the shifter, hold_full=0, bit_count=0, frame_start=1, and the FSM stays in SHIFT.
  - Else, if a load is accepted in the same cycle, that word bypasses hold into the shifter, with frame_start=1 and the FSM staying in SHIFT.
  - Else the FSM goes to IDLE and out=0.
- With enable low, the shifter, bit_count and out hold their values. Loads into hold are still accepted.
- Invariant: hold_full is never 1 in IDLE.
- Shift rule:
  - MSB_FIRST=1: out = shifter[SIZE-1], shifting left with 0 fill.
  - MSB_FIRST=0: out = shifter[0], shifting right with 0 fill.
- Reset mid-frame: the in-flight word and the held word are discarded, with no done pulse. Reset has priority over load and enable in the same cycle.

## Timing
- Load accepted at edge N in IDLE: the first bit appears on out after edge N.
- Each frame occupies exactly SIZE enabled cycles. The last bit is on out until the edge that consumes it, and done is high for the cycle after that edge.
- Back-to-back frames: bit 0 of frame k+1 follows the last bit of frame k on the very next enabled edge, with zero gap.
- load_ready deasserts the cycle after hold fills. It reasserts the cycle after hold drains at end of frame.
- There is no combinational path from inputs to outputs; load_ready depends on registered state only.

## Structure
- State encodings (IDLE=0, SHIFT=1) are localparams in the shared shifting definitions header that other shifting blocks include.
- The shifter is one natural sub-module, parallel_load_shift_register. It has parameters SIZE and MSB_FIRST and ports clk, reset, load, load_data, enable, and a full parallel output. Out is taken from its output-end bit.
- The FSM, counter and hold buffer live in the top module.

## Test plan
- Reset then single frame: SIZE=8, MSB_FIRST=1, enable held at 1, load 8'hA5 -> out reads 1,0,1,0,0,1,0,1 on consecutive cycles; frame_start=1 on the first bit only; done pulses once; then IDLE with out=0 and busy=0.
- LSB-first: MSB_FIRST=0, load 8'h01 -> out reads 1 followed by seven 0s.
- Back-to-back: load 8'hFF and then 8'h00 while the first word is shifting -> 16 contiguous bits (eight 1s, eight 0s) with no gap; load_ready is low while hold is full; frame_start pulses at bit 0 and bit 8.
- Enable gating: toggle enable 1,0,0,1 during a frame of 8'hC3 -> out holds its value through the low cycles; the full bit sequence is still 1,1,0,0,0,0,1,1; done comes only after 8 enabled cycles.
- End-of-frame bypass: hold empty, and a load of 8'h81 is accepted on the same edge that consumes the last bit of the prior frame -> 8'h81 begins on the next cycle with no gap and hold_full stays 0.
- Reset mid-frame: assert reset after 3 bits with hold full -> next cycle out=0, busy=0, load_ready=1, no done pulse, and no held data is emitted afterward.
